// File: rtl/div_scheduler_pkg.sv
// rtl/div_scheduler_pkg.sv - shared types and constants for the divider scheduler
package div_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    RESP
  } div_sched_state_t;

  // Quotient reported for a zero divisor: all ones of the given width (width <= 32).
  function automatic logic [31:0] dbz_quotient(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// rtl/div_scheduler_if.sv - requester, response and divider signals of the scheduler
interface div_scheduler_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_dbz;

  logic                  div_start;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;
  logic                  div_done;

  modport master (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    input  div_quotient, div_remainder, div_done,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
    output div_start, div_dividend, div_divisor
  );

  modport slave (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    output div_quotient, div_remainder, div_done,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
    input  div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/div_scheduler_rr_picker.sv
// rtl/div_scheduler_rr_picker.sv - combinational round-robin picker starting after the pointer
module rr_picker #(
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any_valid && req[cand]) begin
        any_valid   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin front end sharing one sequential divider
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  div_scheduler_if.master bus
);

  div_sched_state_t state, state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant;
  logic             any_valid;
  logic             accept;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign sel_dividend = bus.req_dividend[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_divisor  = bus.req_divisor[int'(grant_idx)*WIDTH +: WIDTH];

  // Gated by reset_n so the grant cannot leak out while reset is held.
  assign bus.req_ready = (reset_n && state == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept     = 1'b1;
          state_next = (sel_divisor == '0) ? RESP : ISSUE;
        end
      end
      ISSUE:   state_next = ARM;
      // done may still be high from the previous job here, so it is not looked at.
      ARM:     state_next = WAIT;
      WAIT:    if (bus.div_done) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr               <= IDW'(NREQ - 1);
      bus.div_start     <= 1'b0;
      bus.div_dividend  <= '0;
      bus.div_divisor   <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_quotient  <= '0;
      bus.rsp_remainder <= '0;
      bus.rsp_dbz       <= 1'b0;
    end else begin
      bus.div_start <= (state_next == ISSUE);
      bus.rsp_valid <= (state_next == RESP);
      if (accept) begin
        ptr              <= grant_idx;
        bus.rsp_id       <= grant_idx;
        bus.div_dividend <= sel_dividend;
        bus.div_divisor  <= sel_divisor;
        if (sel_divisor == '0) begin
          bus.rsp_quotient  <= WIDTH'(dbz_quotient(WIDTH));
          bus.rsp_remainder <= sel_dividend;
          bus.rsp_dbz       <= 1'b1;
        end
      end
      if (state == WAIT && bus.div_done) begin
        bus.rsp_quotient  <= bus.div_quotient;
        bus.rsp_remainder <= bus.div_remainder;
        bus.rsp_dbz       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - self-checking bench for div_scheduler with a behavioural divider
module tb_div_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   exp_ptr  = NREQ - 1;

  always #5 clk = ~clk;

  div_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  div_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Sequential divider: WIDTH steps after start, done held until the next start.
  logic div_reset;
  int   div_cnt;
  assign div_reset = ~reset_n;

  always @(posedge clk or posedge div_reset) begin
    if (div_reset) begin
      div_cnt           <= 0;
      bus.div_done      <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
    end else if (bus.div_start) begin
      div_cnt      <= WIDTH;
      bus.div_done <= 1'b0;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        bus.div_done      <= 1'b1;
        bus.div_quotient  <= bus.div_dividend / bus.div_divisor;
        bus.div_remainder <= bus.div_dividend % bus.div_divisor;
      end
    end
  end

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int v, input int dvd, input int dvs);
    logic [WIDTH-1:0] a, b;
    a = WIDTH'(dvd);
    b = WIDTH'(dvs);
    bus.req_valid[id]                    = v[0];
    bus.req_dividend[id*WIDTH +: WIDTH]  = a;
    bus.req_divisor[id*WIDTH +: WIDTH]   = b;
  endtask

  // Drives one job from requester id, measures latency from acceptance and takes the response.
  task automatic do_job(input int id, input int dvd, input int dvs,
                        output int lat, output int starts, output int rid,
                        output int q, output int r, output int dbz);
    int guard;
    lat = -1; starts = 0; rid = -1; q = -1; r = -1; dbz = -1;
    set_req(id, 1, dvd, dvs);
    #1;
    guard = 0;
    while (!bus.req_ready[id] && guard < 30) begin
      step();
      guard++;
    end
    if (guard >= 30) begin
      set_req(id, 0, 0, 0);
      return;
    end
    exp_ptr = id;
    step();
    set_req(id, 0, 0, 0);
    for (int n = 1; n <= 40; n++) begin
      if (bus.div_start) starts++;
      if (bus.rsp_valid) begin
        lat = n; rid = int'(bus.rsp_id); q = int'(bus.rsp_quotient);
        r = int'(bus.rsp_remainder); dbz = int'(bus.rsp_dbz);
        break;
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, 1, k + 3, k + 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.div_start, bus.rsp_dbz} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.rsp_valid, bus.div_start, bus.rsp_dbz});
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.div_dividend, bus.div_divisor} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0",
        {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.div_dividend, bus.div_divisor});
    end
    bus.req_valid = '0;
    #2 reset_n = 1'b1;
    exp_ptr = NREQ - 1;
    step();
  endtask

  task automatic test_round_robin();
    int dva[NREQ], dvb[NREQ];
    int cyc, last_acc, acc, rsp, pend_id, pend_a, pend_b, reload, e;
    logic [NREQ-1:0] oh;
    cyc = 0; last_acc = -1; acc = 0; rsp = 0; pend_id = -1; pend_a = 0; pend_b = 1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      dva[k] = $urandom_range(0, 15);
      dvb[k] = $urandom_range(1, 15);
      set_req(k, 1, dva[k], dvb[k]);
    end
    #1;
    while (rsp < 5 && cyc < 100) begin
      reload = -1;
      if (bus.rsp_valid) begin
        checks++;
        if (int'(bus.rsp_id) !== pend_id || int'(bus.rsp_quotient) !== pend_a / pend_b ||
            int'(bus.rsp_remainder) !== pend_a % pend_b || bus.rsp_dbz !== 1'b0) begin
          failures++;
          $display("FAIL rr_result got id=%0d q=%0d r=%0d dbz=%0d exp id=%0d q=%0d r=%0d dbz=0",
                   bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, pend_id, pend_a / pend_b, pend_a % pend_b);
        end
        rsp++;
      end
      if (bus.req_ready != '0) begin
        e = exp_grant(bus.req_valid);
        oh = '0;
        oh[e] = 1'b1;
        checks++;
        if (bus.req_ready !== oh) begin failures++; $display("FAIL rr_grant got=%b exp=%b", bus.req_ready, oh); end
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== WIDTH + 4) begin
            failures++; $display("FAIL rr_spacing got=%0d exp=%0d", cyc - last_acc, WIDTH + 4);
          end
        end
        last_acc = cyc; pend_id = e; pend_a = dva[e]; pend_b = dvb[e];
        exp_ptr = e; acc++; reload = e;
      end
      step();
      cyc++;
      if (reload >= 0) begin
        if (acc >= 5) begin
          bus.req_valid = '0;
        end else begin
          dva[reload] = $urandom_range(0, 15);
          dvb[reload] = $urandom_range(1, 15);
          set_req(reload, 1, dva[reload], dvb[reload]);
        end
      end
    end
    checks++;
    if (rsp !== 5 || acc !== 5) begin failures++; $display("FAIL rr_count got acc=%0d rsp=%0d exp=5", acc, rsp); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_single_job();
    int lat, st, rid, q, r, dbz, id, a, b;
    do_job(2, 13, 4, lat, st, rid, q, r, dbz);
    checks++;
    if (lat !== WIDTH + 3) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, WIDTH + 3); end
    checks++;
    if (rid !== 2 || q !== 3 || r !== 1 || dbz !== 0) begin
      failures++; $display("FAIL single_result got id=%0d q=%0d r=%0d dbz=%0d exp id=2 q=3 r=1 dbz=0", rid, q, r, dbz);
    end
    checks++;
    if (st !== 1) begin failures++; $display("FAIL single_start_pulses got=%0d exp=1", st); end
    for (int n = 0; n < 8; n++) begin
      id = $urandom_range(0, NREQ - 1);
      a  = $urandom_range(0, 15);
      b  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      do_job(id, a, b, lat, st, rid, q, r, dbz);
      checks++;
      if (lat !== ((b == 0) ? 1 : WIDTH + 3) || rid !== id || q !== ((b == 0) ? 15 : a / b) ||
          r !== ((b == 0) ? a : a % b) || dbz !== ((b == 0) ? 1 : 0) || st !== ((b == 0) ? 0 : 1)) begin
        failures++;
        $display("FAIL random_job %0d/%0d got lat=%0d id=%0d q=%0d r=%0d dbz=%0d starts=%0d exp id=%0d",
                 a, b, lat, rid, q, r, dbz, st, id);
      end
    end
  endtask

  task automatic test_dbz();
    int lat, st, rid, q, r, dbz;
    do_job(1, 9, 0, lat, st, rid, q, r, dbz);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++;
    if (rid !== 1 || q !== 15 || r !== 9 || dbz !== 1) begin
      failures++; $display("FAIL dbz_result got id=%0d q=%0d r=%0d dbz=%0d exp id=1 q=15 r=9 dbz=1", rid, q, r, dbz);
    end
    checks++;
    if (st !== 0) begin failures++; $display("FAIL dbz_start got=%0d exp=0", st); end
  endtask

  task automatic test_stall();
    int id, other, g, a, b, lat, st, rid, q, r, dbz, e;
    logic [NREQ-1:0] oh;
    id    = $urandom_range(0, NREQ - 1);
    other = (id + 1 + $urandom_range(0, NREQ - 2)) % NREQ;
    set_req(id, 1, 15, 2);
    #1;
    g = 0;
    while (!bus.req_ready[id] && g < 30) begin step(); g++; end
    exp_ptr = id;
    step();
    set_req(id, 0, 0, 0);
    g = 0;
    while (!bus.rsp_valid && g < 20) begin step(); g++; end
    a = $urandom_range(0, 15);
    b = $urandom_range(1, 15);
    set_req(other, 1, a, b);
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) !== id || bus.rsp_quotient !== 4'd7 ||
          bus.rsp_remainder !== 4'd1 || bus.rsp_dbz !== 1'b0) begin
        failures++; $display("FAIL stall_hold got v=%0d id=%0d q=%0d r=%0d exp v=1 id=%0d q=7 r=1",
                             bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, id);
      end
      checks++;
      if (bus.req_ready !== '0) begin failures++; $display("FAIL stall_req_ready got=%b exp=0", bus.req_ready); end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    e = exp_grant(bus.req_valid);
    oh = '0;
    oh[e] = 1'b1;
    checks++;
    if (bus.req_ready !== oh) begin failures++; $display("FAIL stall_next_accept got=%b exp=%b", bus.req_ready, oh); end
    do_job(other, a, b, lat, st, rid, q, r, dbz);
    checks++;
    if (lat !== WIDTH + 3 || q !== a / b || r !== a % b) begin
      failures++; $display("FAIL stall_followup got lat=%0d q=%0d r=%0d exp lat=%0d q=%0d r=%0d", lat, q, r, WIDTH + 3, a / b, a % b);
    end
  endtask

  task automatic test_back_to_back();
    int lat, st, rid, q, r, dbz, ia, ib;
    ia = $urandom_range(0, NREQ - 1);
    ib = $urandom_range(0, NREQ - 1);
    do_job(ia, 7, 7, lat, st, rid, q, r, dbz);
    checks++;
    if (q !== 1 || r !== 0) begin failures++; $display("FAIL b2b_first got q=%0d r=%0d exp q=1 r=0", q, r); end
    do_job(ib, 14, 3, lat, st, rid, q, r, dbz);
    checks++;
    if (lat !== WIDTH + 3 || rid !== ib || q !== 4 || r !== 2) begin
      failures++; $display("FAIL b2b_second got lat=%0d id=%0d q=%0d r=%0d exp lat=%0d id=%0d q=4 r=2", lat, rid, q, r, WIDTH + 3, ib);
    end
  endtask

  task automatic test_reset_in_wait();
    int id, g, seen, lat, st, rid, q, r, dbz;
    id = $urandom_range(0, NREQ - 1);
    set_req(id, 1, $urandom_range(0, 15), $urandom_range(1, 15));
    #1;
    g = 0;
    while (!bus.req_ready[id] && g < 30) begin step(); g++; end
    step();
    set_req(id, 0, 0, 0);
    repeat (3) step();
    set_req((id + 1) % NREQ, 1, 5, 2);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.div_start, bus.rsp_dbz} !== 3'b000 || bus.req_ready !== '0) begin
      failures++; $display("FAIL wait_reset_flags got v=%0d s=%0d dbz=%0d rdy=%b exp all 0",
                           bus.rsp_valid, bus.div_start, bus.rsp_dbz, bus.req_ready);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.div_dividend, bus.div_divisor} !== '0) begin
      failures++; $display("FAIL wait_reset_data got=%h exp=0",
        {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.div_dividend, bus.div_divisor});
    end
    exp_ptr = NREQ - 1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL wait_reset_no_rsp got=%0d exp=0", seen); end
    for (int k = 0; k < NREQ; k++) set_req(k, 1, 11, 3);
    #1;
    checks++;
    if (bus.req_ready !== NREQ'(1)) begin failures++; $display("FAIL wait_reset_first_grant got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    do_job(0, 11, 3, lat, st, rid, q, r, dbz);
    checks++;
    if (rid !== 0 || q !== 3 || r !== 2) begin
      failures++; $display("FAIL wait_reset_job got id=%0d q=%0d r=%0d exp id=0 q=3 r=2", rid, q, r);
    end
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_round_robin();
    test_single_job();
    test_dbz();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Round-robin scheduler sharing one sequential `divider` instance between `NREQ` requesters. It accepts one division job at a time over per-requester valid/ready ports and issues it to the divider with a one-cycle `start`. It waits for the divider's `done`, then returns the result on a single tagged response port with valid/ready flow control. Divide-by-zero is resolved locally without engaging the divider.

## Interface
- `WIDTH`, 4: operand/result width; must match the attached divider.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester-id width (derived, not overridden).

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester job valid.
- `req_ready`  out  NREQ  one-hot accept; a job transfers when `req_valid[i] && req_ready[i]`.
- `req_dividend`  in  NREQ*WIDTH  requester i in bits `[i*WIDTH +: WIDTH]`.
- `req_divisor`  in  NREQ*WIDTH  same packing.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  requester index of the result.
- `rsp_quotient`, `rsp_remainder`  out  WIDTH  result.
- `rsp_dbz`  out  1  divisor was zero.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_dividend`, `div_divisor`  out  WIDTH  operands, held stable from `div_start` until `done` is seen.
- `div_quotient`, `div_remainder`  in  WIDTH  divider results.
- `div_done`  in  1  divider completion level.

## Operation
- FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE: if any `req_valid`, the round-robin picker selects winner w; `req_ready` = one-hot(w) combinationally in that cycle only; all other states drive `req_ready` = 0. On transfer, latch id and operands, and set the priority pointer to w.
  - divisor != 0 -> ISSUE.
  - divisor == 0 -> RESP with quotient = all ones, remainder = dividend, `rsp_dbz` = 1. Divider is not started.
- Round-robin: search starts at pointer+1 mod NREQ. The pointer resets to NREQ-1, so requester 0 wins first. The pointer updates only on an accepted job.
- ISSUE: `div_start` = 1 for exactly this cycle -> ARM.
- ARM: `div_done` ignored. It may still be high from the previous job; the divider clears it on the `start` edge. -> WAIT.
- WAIT: on `div_done` = 1, register `div_quotient`/`div_remainder` into the response, `rsp_dbz` = 0 -> RESP.
- RESP: `rsp_valid` = 1. All `rsp_*` are held stable until `rsp_ready`. On handshake -> IDLE. No new job is accepted during RESP, so there is one job in flight at most.
- Requesters must hold `req_valid` and operands until accepted. A requester dropping `req_valid` before acceptance loses no state.
- Reset (any state, asynchronous): state = IDLE, pointer = NREQ-1, and all outputs 0, including `req_ready`, `div_start`, `rsp_valid`, `rsp_id`, `rsp_quotient`, `rsp_remainder`, `rsp_dbz`, `div_dividend` and `div_divisor`. A job in flight is dropped with no response. The divider must share reset with this block, through an inverter on its active-high `reset`.

## Timing
- Acceptance in cycle 0 (IDLE edge).
- `div_start` high in cycle 1.
- The divider steps in cycles 2..WIDTH+1, and `div_done` is seen in cycle WIDTH+2.
- `rsp_valid` rises in cycle WIDTH+3 (divider latency + 3).
- Divide-by-zero: `rsp_valid` in cycle 1.
- Minimum job-to-job spacing is WIDTH+4 cycles with `rsp_ready` tied high. The next acceptance happens the cycle after the response handshake.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, state and pointer.

## Structure
- Package `div_sched_pkg`: state enum `div_sched_state_t` (IDLE, ISSUE, ARM, WAIT, RESP) and a function for the divide-by-zero quotient constant (all ones of WIDTH).
- Sub-module `rr_picker #(NREQ)`: inputs request vector and pointer; outputs one-hot grant, grant index and any-valid flag. It is purely combinational.
- The top contains the FSM, operand/response registers and pointer. The divider is instantiated by the parent, not inside this block.

## Test plan
- WIDTH=4, NREQ=4, single job from req 2, 13/4 -> `rsp_valid` at cycle 7 after acceptance, id=2, q=3, r=1, dbz=0, `div_start` exactly one cycle.
- All four `req_valid` held high, `rsp_ready`=1 -> grant order 0,1,2,3,0. Each result carries the matching id and correct quotient.
- req 1 divisor 0, dividend 9 -> `rsp_valid` next cycle, q=15, r=9, dbz=1. `div_start` never asserts.
- `rsp_ready` held low 5 cycles after 15/2 -> `rsp_*` stable (q=7, r=1). No `req_ready` during the stall. The next job is accepted the cycle after the handshake.
- Back-to-back jobs 7/7 then 14/3 -> second result q=4, r=2, proving stale `div_done` is ignored in ARM.
- Deassert `reset_n` in WAIT -> all outputs 0 immediately. No response is emitted. After release, the first grant goes to req 0.
